// File: rtl/wb_byte_master.sv
// rtl/wb_byte_master.sv - byte-stream command frames to Wishbone B3 classic single read/write accesses
// Optional bus-cycle timeout with 'T' response: define WB_BYTE_MASTER_TIMEOUT_EN.
module wb_byte_master #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] CMD_WRITE      = 8'h57,
    parameter logic [7:0] CMD_READ       = 8'h52
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h45;
    localparam logic [7:0] RESP_TMO = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rd_q;
    logic        we_q;
    logic        cyc_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [2:0]  resp_left_q;

    logic rx_fire;
    logic tx_fire;
    logic term;
    logic abort;
    logic field_end;
    logic is_cmd;

    assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign rx_fire    = rx_valid_i & rx_ready_o;
    assign tx_fire    = tx_valid_q & tx_ready_i;
    assign term       = cyc_q & (wb_ack_i | wb_err_i | wb_rty_i);
    assign field_end  = rx_fire & (cnt_q == 2'd3);
    assign is_cmd     = (rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ);

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt_q;

    // Counts cycles with cyc high; cleared whenever the bus phase is not active.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || state_q != S_BUS) begin
            to_cnt_q <= '0;
        end else if (cyc_q) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign abort = cyc_q & ~term & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rx_fire && is_cmd) state_d = S_ADDR;
            S_ADDR:  if (field_end) state_d = we_q ? S_WDATA : S_BUS;
            S_WDATA: if (field_end) state_d = S_BUS;
            S_BUS:   if (term || abort) state_d = S_RESP;
            S_RESP:  if (tx_fire && resp_left_q == 3'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cnt_q       <= 2'd0;
            adr_q       <= '0;
            dat_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            resp_left_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_fire && is_cmd) begin
                        we_q  <= (rx_data_i == CMD_WRITE);
                        cnt_q <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        adr_q <= {adr_q[23:0], rx_data_i};
                        cnt_q <= cnt_q + 2'd1;
                        if (field_end && !we_q) cyc_q <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (rx_fire) begin
                        dat_q <= {dat_q[23:0], rx_data_i};
                        cnt_q <= cnt_q + 2'd1;
                        if (field_end) cyc_q <= 1'b1;
                    end
                end
                S_BUS: begin
                    // err outranks rty, which outranks ack; only a clean read ack returns data
                    if (term) begin
                        cyc_q      <= 1'b0;
                        tx_valid_q <= 1'b1;
                        if (wb_err_i || wb_rty_i) begin
                            tx_data_q   <= RESP_ERR;
                            resp_left_q <= 3'd0;
                        end else begin
                            tx_data_q   <= RESP_OK;
                            resp_left_q <= we_q ? 3'd0 : 3'd4;
                            if (!we_q) rd_q <= wb_dat_i;
                        end
                    end else if (abort) begin
                        cyc_q       <= 1'b0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= RESP_TMO;
                        resp_left_q <= 3'd0;
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (resp_left_q != 3'd0) begin
                            tx_data_q   <= rd_q[31:24];
                            rd_q        <= {rd_q[23:0], 8'h00};
                            resp_left_q <= resp_left_q - 3'd1;
                        end else begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = 4'hF;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;

endmodule
